loadable_rom: RTL and testbench

LOADABLE_ROM -- requirements
Module: loadable_rom

---
 rtl/loadable_rom.sv | 103 ++++++++++
 tb/tb_loadable_rom.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/loadable_rom.sv
// Loadable program ROM: streams a program into a single memory array, then
// serves word fetches (registered or combinational) once the download completes.
`ifndef A_BITS
`define A_BITS 8
`endif
`ifndef D_BITS
`define D_BITS 32
`endif

module loadable_rom #(
    parameter int ADDR_W  = `A_BITS,
    parameter int DATA_W  = `D_BITS,
    parameter bit REG_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              loaded,
    output logic              load_full,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              data_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic              wr_en;
    logic              hit;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] mem [DEPTH];

    assign load_ready = (state == LOAD);
    // load_start and rst both pre-empt a word presented in the same cycle
    assign wr_en      = load_ready && load_valid && !load_start && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wptr       <= '0;
            load_count <= '0;
            loaded     <= 1'b0;
            load_full  <= 1'b0;
        end else if (load_start) begin
            state      <= LOAD;
            wptr       <= '0;
            load_count <= '0;
            loaded     <= 1'b0;
            load_full  <= 1'b0;
        end else if (wr_en) begin
            wptr       <= wptr + 1'b1;
            load_count <= load_count + 1'b1;
            if (load_last || wptr == ADDR_W'(DEPTH - 1)) begin
                state     <= READY;
                loaded    <= 1'b1;
                load_full <= !load_last;
            end
        end
    end

    // Memory is deliberately not reset; load_count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= load_data;
        end
    end

    assign hit  = ({1'b0, addr} < load_count);
    assign word = (loaded && hit) ? mem[addr] : '0;

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    data       <= '0;
                    data_valid <= 1'b0;
                end else begin
                    data_valid <= fetch_en && loaded;
                    if (fetch_en) begin
                        data <= word;
                    end
                end
            end
        end else begin : g_comb
            always_comb begin
                data_valid = fetch_en && loaded;
                data       = (fetch_en && loaded) ? word : '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_loadable_rom.sv
// Directed bench for loadable_rom: registered instance plus a combinational
// instance driven by the same stimulus.
module tb_loadable_rom;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, load_start, load_valid, load_last, fetch_en;
    logic [DW-1:0] load_data;
    logic [AW-1:0] addr;

    logic          load_ready, loaded, load_full, data_valid;
    logic [AW:0]   load_count;
    logic [DW-1:0] data;

    logic          c_load_ready, c_loaded, c_load_full, c_data_valid;
    logic [AW:0]   c_load_count;
    logic [DW-1:0] c_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    loadable_rom #(.ADDR_W(AW), .DATA_W(DW), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .load_count(load_count), .loaded(loaded), .load_full(load_full),
        .fetch_en(fetch_en), .addr(addr), .data(data), .data_valid(data_valid)
    );

    loadable_rom #(.ADDR_W(AW), .DATA_W(DW), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(c_load_ready),
        .load_count(c_load_count), .loaded(c_loaded), .load_full(c_load_full),
        .fetch_en(fetch_en), .addr(addr), .data(c_data), .data_valid(c_data_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = '0; fetch_en = 1'b0; addr = '0;
        tick(); tick();
        chk("rst_loaded", loaded, 0);
        chk("rst_count", load_count, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_full", load_full, 0);
        chk("rst_data", data, 0);
        chk("rst_dv", data_valid, 0);

        // Three-word program, last on the third word
        rst = 1'b0; load_start = 1'b1; tick(); load_start = 1'b0;
        chk("ld_ready", load_ready, 1);
        chk("ld_count0", load_count, 0);
        load_valid = 1'b1; load_data = 8'h11; tick();
        load_data = 8'h22; tick();
        load_data = 8'h33; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("ld3_count", load_count, 3);
        chk("ld3_loaded", loaded, 1);
        chk("ld3_ready", load_ready, 0);
        chk("ld3_full", load_full, 0);

        fetch_en = 1'b1; addr = 3'd1; #1;
        chk("c_a1_data", c_data, 8'h22);
        chk("c_a1_dv", c_data_valid, 1);
        tick();
        chk("a1_data", data, 8'h22);
        chk("a1_dv", data_valid, 1);
        addr = 3'd5; tick();
        chk("a5_data", data, 0);
        chk("a5_dv", data_valid, 1);
        addr = 3'd2; tick();
        chk("a2_data", data, 8'h33);
        fetch_en = 1'b0; addr = 3'd0; #1;
        chk("c_noen_dv", c_data_valid, 0);
        tick();
        chk("noen_dv", data_valid, 0);
        chk("noen_hold", data, 8'h33);

        // Combinational instance follows addr within the cycle
        fetch_en = 1'b1; addr = 3'd0; #1;
        chk("c_a0_data", c_data, 8'h11);
        addr = 3'd1; #1;
        chk("c_chg_data", c_data, 8'h22);

        // Fetch in the load_start cycle still sees the old program
        addr = 3'd0; load_start = 1'b1; tick(); load_start = 1'b0;
        chk("rl_data", data, 8'h11);
        chk("rl_dv", data_valid, 1);
        chk("rl_loaded", loaded, 0);
        chk("rl_count", load_count, 0);
        chk("c_rl_dv", c_data_valid, 0);
        tick();
        chk("rl2_dv", data_valid, 0);
        chk("rl2_data", data, 0);
        fetch_en = 1'b0;

        // Fill all 8 words without load_last
        load_valid = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            load_data = 8'h40 + 8'(i); tick();
        end
        chk("full_count", load_count, 8);
        chk("full_flag", load_full, 1);
        chk("full_loaded", loaded, 1);
        chk("full_ready", load_ready, 0);
        load_data = 8'hEE; tick();
        load_valid = 1'b0;
        chk("extra_count", load_count, 8);
        fetch_en = 1'b1; addr = 3'd7; tick();
        chk("full_a7", data, 8'h47);
        addr = 3'd0; tick();
        chk("full_a0", data, 8'h40);
        fetch_en = 1'b0;

        // load_start beats a simultaneous word; then one-word reload
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'h99; load_last = 1'b1; tick();
        load_start = 1'b0;
        chk("pri_count", load_count, 0);
        chk("pri_loaded", loaded, 0);
        chk("pri_ready", load_ready, 1);
        load_data = 8'hAA; tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("one_count", load_count, 1);
        chk("one_loaded", loaded, 1);
        chk("one_full", load_full, 0);
        fetch_en = 1'b1; addr = 3'd0; tick();
        chk("one_a0", data, 8'hAA);
        addr = 3'd1; tick();
        chk("one_a1", data, 0);
        chk("one_a1_dv", data_valid, 1);
        fetch_en = 1'b0;

        // Reset mid-download
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_valid = 1'b1; load_data = 8'h01; tick();
        load_data = 8'h02; tick();
        load_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_loaded", loaded, 0);
        chk("mid_count", load_count, 0);
        chk("mid_ready", load_ready, 0);
        fetch_en = 1'b1; addr = 3'd0; tick();
        chk("mid_dv", data_valid, 0);
        chk("mid_data", data, 0);
        fetch_en = 1'b0;

        // rst outranks load_start
        rst = 1'b1; load_start = 1'b1; tick(); rst = 1'b0; load_start = 1'b0;
        chk("rstpri_ready", load_ready, 0);
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_valid = 1'b1; load_last = 1'b1; load_data = 8'h5A; tick();
        load_valid = 1'b0; load_last = 1'b0;
        fetch_en = 1'b1; addr = 3'd0; tick();
        chk("restart_a0", data, 8'h5A);
        chk("restart_count", load_count, 1);
        fetch_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
